rsqrt_newton_refine: RTL and testbench

//  Consumer end of the inverse-sqrt seed path: takes operand x and seed y0 ~ 1/sqrt(x).

---
 rtl/rsqrt_pkg.sv | 23 ++
 rtl/fxp_mul_q.sv | 18 +
 rtl/rsqrt_newton_refine.sv | 155 +++++++++++++++
 tb/tb_rsqrt_newton_refine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rsqrt_pkg.sv
// rtl/rsqrt_pkg.sv - shared constants, state encoding and saturation for the rsqrt refiner
package rsqrt_pkg;

   localparam int W    = 32;
   localparam int FRAC = 10;
   localparam int SW   = $clog2(2 * W);

   localparam logic [W-1:0] THREE_Q = W'(3) << FRAC;

   typedef enum logic [2:0] {
      IDLE,
      S_YY,
      S_XYY,
      S_Y,
      DONE
   } state_t;

   // Any set bit above the low W bits means the value does not fit: clamp to all-ones.
   function automatic logic [W-1:0] sat_w(input logic [2*W-1:0] v);
      return (v[2*W-1:W] != '0) ? {W{1'b1}} : v[W-1:0];
   endfunction

endpackage

// File: rtl/fxp_mul_q.sv
// rtl/fxp_mul_q.sv - combinational unsigned a*b >> shift, saturated to W bits
module fxp_mul_q
   import rsqrt_pkg::*;
(
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [SW-1:0] shift,
   output logic [W-1:0]  y
);

   logic [2*W-1:0] prod;
   logic [2*W-1:0] shifted;

   assign prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   assign shifted = prod >> shift;
   assign y       = sat_w(shifted);

endmodule

// File: rtl/rsqrt_newton_refine.sv
// rtl/rsqrt_newton_refine.sv - Newton-Raphson refinement of an inverse-sqrt seed
module rsqrt_newton_refine
   import rsqrt_pkg::*;
#(
   parameter int ITER = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x_in,
   input  logic [W-1:0] y0_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y_out
);

   generate
      if (ITER < 1) begin : g_iter_check
         $error("rsqrt_newton_refine: ITER must be >= 1");
      end
   endgenerate

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   state_t        state_q, state_d;
   logic [W-1:0]  x_q, x_d;
   logic [W-1:0]  y_q, y_d;
   logic [W-1:0]  p_q, p_d;
   logic [W-1:0]  t_q, t_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  y_out_q, y_out_d;

   logic [W-1:0]  mul_a;
   logic [W-1:0]  mul_b;
   logic [SW-1:0] mul_sh;
   logic [W-1:0]  mul_y;

   // One multiplier serves all three steps; operands follow the state.
   always_comb begin
      mul_a  = '0;
      mul_b  = '0;
      mul_sh = SW'(FRAC);
      case (state_q)
         S_YY: begin
            mul_a = y_q;
            mul_b = y_q;
         end
         S_XYY: begin
            mul_a = x_q;
            mul_b = p_q;
         end
         S_Y: begin
            mul_a  = y_q;
            mul_b  = t_q;
            mul_sh = SW'(FRAC + 1);
         end
         default: ;
      endcase
   end

   fxp_mul_q u_mul (
      .a     (mul_a),
      .b     (mul_b),
      .shift (mul_sh),
      .y     (mul_y)
   );

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      p_d         = p_q;
      t_d         = t_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      y_out_d     = y_out_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               x_d        = x_in;
               y_d        = y0_in;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = S_YY;
            end
         end
         S_YY: begin
            p_d     = mul_y;
            state_d = S_XYY;
         end
         S_XYY: begin
            // Overshoot (x*y*y >= 3) would go negative; clamp the correction to zero.
            t_d     = (mul_y >= THREE_Q) ? '0 : (THREE_Q - mul_y);
            state_d = S_Y;
         end
         S_Y: begin
            y_d = mul_y;
            if (cnt_q == CNT_LAST) begin
               y_out_d     = mul_y;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = S_YY;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         p_q         <= '0;
         t_q         <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         y_out_q     <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         p_q         <= p_d;
         t_q         <= t_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         y_out_q     <= y_out_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y_out     = y_out_q;

endmodule

// File: tb/tb_rsqrt_newton_refine.sv
// tb/tb_rsqrt_newton_refine.sv - self-checking bench for rsqrt_newton_refine
module tb_rsqrt_newton_refine;

   localparam int ITER = 2;
   localparam int LAT  = 3 * ITER;
   localparam longint unsigned MAXV = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x_in = '0;
   logic [31:0] y0_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] y_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rsqrt_newton_refine #(.ITER(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y0_in     (y0_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out)
   );

   function automatic longint unsigned clamp(input longint unsigned v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   // y <- y*(3 - x*y*y)/2 in Q.10, each product truncated then clamped to 32 bits.
   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y0);
      longint unsigned y, p, q, t, xx;
      xx = 64'(x);
      y  = 64'(y0);
      for (int i = 0; i < ITER; i++) begin
         p = clamp((y * y) / 1024);
         q = clamp((xx * p) / 1024);
         t = (q >= 3072) ? 0 : 3072 - q;
         y = clamp((y * t) / 2048);
      end
      return y[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand pair and wait for out_valid; returns cycles from accept edge.
   task automatic start_and_wait(input logic [31:0] x, input logic [31:0] y0,
                                 output int lat, output logic [31:0] res);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      in_valid = 1'b1;
      x_in     = x;
      y0_in    = y0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      res = y_out;
   endtask

   task automatic run_case(input string name, input logic [31:0] x, input logic [31:0] y0,
                           input logic [31:0] exp_y);
      int lat;
      logic [31:0] res;
      start_and_wait(x, y0, lat, res);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
      end
      checks++;
      if (res !== exp_y) begin
         errors++;
         $display("FAIL %s y_out: got %0d expected %0d", name, res, exp_y);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== 32'd0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b y_out=%0d expected 1/0/0", in_ready, out_valid, y_out);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      run_case("converged", 32'd4096, 32'd512, 32'd512);
      run_case("refine", 32'd4096, 32'd256, 32'd444);
      run_case("x_zero", 32'd0, 32'd512, 32'd1152);
      run_case("x_zero_sat", 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_case("overshoot", 32'd4096, 32'd2048, 32'd0);
      checks++;
      if (y_out !== 32'd0) begin
         errors++;
         $display("FAIL hold_after_idle: got %0d expected 0", y_out);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [31:0] res;
      logic [31:0] exp_y;
      exp_y     = model(32'd4096, 32'd256);
      out_ready = 1'b0;
      start_and_wait(32'd4096, 32'd256, lat, res);
      checks++;
      if (res !== exp_y || lat !== LAT) begin
         errors++;
         $display("FAIL bp_result: got %0d lat %0d expected %0d lat %0d", res, lat, exp_y, LAT);
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         x_in     = $urandom;
         y0_in    = $urandom;
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || y_out !== exp_y) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b y_out=%0d expected 1/0/%0d",
                     i, out_valid, in_ready, y_out, exp_y);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== exp_y) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b y_out=%0d expected 1/0/%0d",
                  in_ready, out_valid, y_out, exp_y);
      end
      run_case("bp_next", 32'd0, 32'd512, 32'd1152);
   endtask

   task automatic test_reset_abort();
      in_valid = 1'b1;
      x_in     = 32'd4096;
      y0_in    = 32'd512;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== 32'd0) begin
         errors++;
         $display("FAIL abort: in_ready=%b out_valid=%b y_out=%0d expected 1/0/0", in_ready, out_valid, y_out);
      end
      run_case("after_abort", 32'd4096, 32'd256, 32'd444);
   endtask

   task automatic test_random();
      logic [31:0] x, y0;
      for (int n = 0; n < 24; n++) begin
         case (n % 3)
            0: begin
               x  = $urandom_range(1, 1 << 20);
               y0 = $urandom_range(0, 1 << 12);
            end
            1: begin
               x  = $urandom_range(1, 8192);
               y0 = $urandom_range(0, 4096);
            end
            default: begin
               x  = $urandom;
               y0 = $urandom;
            end
         endcase
         run_case($sformatf("rand%0d", n), x, y0, model(x, y0));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
